// File: rtl/seg_scan_mux.sv
// seg_scan_mux: double-buffered 4-digit seven-segment scanner with guard-blanked anode multiplexing
module seg_scan_mux #(
  parameter int REFRESH_DIV = 25000,
  parameter int ON_TICKS    = 3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int TW = $clog2(ON_TICKS + 1);
  localparam logic [6:0] LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
    7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};
  typedef enum logic {GUARD, ON} state_t;
  state_t      state;
  logic [DW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [1:0]  d;
  logic [15:0] sh, act, act_sh;
  logic [3:0]  sh_dp, act_dp, v;
  logic        sh_full, tick, last_on, bnd, lz;
  assign din_ready = ~sh_full;
  assign tick      = cnt == DW'(REFRESH_DIV - 1);
  assign last_on   = state == ON && tcnt == TW'(ON_TICKS - 1);
  assign bnd       = tick && last_on && d == 2'd3;
  assign act_sh    = act >> {d, 2'b00};
  assign v         = act_sh[3:0];
  // a digit is a leading zero when it and everything above it is zero
  assign lz        = blank_lz && d != 2'd0 && act_sh == 16'd0;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      cnt        <= '0;
      tcnt       <= '0;
      state      <= GUARD;
      d          <= 2'd0;
      sh         <= '0;
      sh_dp      <= '0;
      sh_full    <= 1'b0;
      act        <= '0;
      act_dp     <= '0;
      seg        <= 7'h7f;
      dp         <= 1'b1;
      an         <= 4'hf;
      frame_done <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        if (state == GUARD) begin
          state <= ON;
          tcnt  <= '0;
        end else if (last_on) begin
          state <= GUARD;
          d     <= d + 1'b1;
        end else
          tcnt <= tcnt + 1'b1;
      end
      if (bnd && sh_full) begin
        act     <= sh;
        act_dp  <= sh_dp;
        sh_full <= 1'b0;
      end else if (din_valid && !sh_full) begin
        sh      <= din;
        sh_dp   <= dp_in;
        sh_full <= 1'b1;
      end
      an         <= state == ON ? ~(4'b1 << d) : 4'hf;
      seg        <= state == ON && !lz ? LUT[v] : 7'h7f;
      dp         <= ~(state == ON && act_dp[d]);
      frame_done <= bnd;
    end
endmodule
